// File: rtl/mmio_responder.sv
// Memory-mapped I/O responder for the core's data-memory port: UART RX FIFO and TX holding
// register, cycle/instruction counters and a counter-reset register behind a 1-cycle read port.
module mmio_responder #(
    parameter int unsigned RX_DEPTH       = 4,
    parameter logic [3:0]  IO_BASE_NIBBLE = 4'h8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int unsigned PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Register map as word indices, i.e. addr[7:2].
    localparam logic [5:0] OFF_STATUS  = 6'h00;
    localparam logic [5:0] OFF_RX_DATA = 6'h01;
    localparam logic [5:0] OFF_TX_DATA = 6'h02;
    localparam logic [5:0] OFF_CYCLE   = 6'h04;
    localparam logic [5:0] OFF_INST    = 6'h05;
    localparam logic [5:0] OFF_CNT_RST = 6'h06;

    logic             sel;
    logic [5:0]       word_off;
    logic             rd_req;
    logic             wr_req;
    logic             wr_any_lane;
    logic             status_wr;
    logic             tx_wr;
    logic             tx_accept;
    logic             cnt_rst;

    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [7:0]       rx_mem_d [RX_DEPTH];
    logic [PTR_W-1:0] rx_rd_ptr_q;
    logic [PTR_W-1:0] rx_rd_ptr_d;
    logic [PTR_W-1:0] rx_wr_ptr_q;
    logic [PTR_W-1:0] rx_wr_ptr_d;
    logic [CNT_W-1:0] rx_count_q;
    logic [CNT_W-1:0] rx_count_d;
    logic             rx_empty;
    logic             rx_full;
    logic             rx_push;
    logic             rx_pop;

    logic [31:0]      rdata_q;
    logic [31:0]      rdata_d;
    logic [7:0]       tx_data_q;
    logic [7:0]       tx_data_d;
    logic             tx_valid_q;
    logic             tx_valid_d;
    logic             tx_overflow_q;
    logic             tx_overflow_d;
    logic [31:0]      cycle_cnt_q;
    logic [31:0]      cycle_cnt_d;
    logic [31:0]      inst_cnt_q;
    logic [31:0]      inst_cnt_d;

    logic             unused_bits;

    assign unused_bits = ^{addr[27:8], addr[1:0], wdata[31:8]};

    // A simultaneous re/we is treated as a write only: no read data, no pop.
    assign sel         = (addr[31:28] == IO_BASE_NIBBLE);
    assign word_off    = addr[7:2];
    assign wr_req      = we && sel;
    assign rd_req      = re && !we && sel;
    assign wr_any_lane = |wmask;

    assign status_wr = wr_req && (word_off == OFF_STATUS) && wr_any_lane;
    assign tx_wr     = wr_req && (word_off == OFF_TX_DATA) && wmask[0];
    assign cnt_rst   = wr_req && (word_off == OFF_CNT_RST) && wr_any_lane;

    // Handshakes: a byte moves on a cycle where valid && ready are both high at the clock edge;
    // valid never depends combinationally on ready, and the data is held stable while valid.
    assign rx_empty  = (rx_count_q == '0);
    assign rx_full   = (rx_count_q == CNT_W'(RX_DEPTH));
    assign rx_push   = uart_rx_valid && !rx_full;
    assign rx_pop    = rd_req && (word_off == OFF_RX_DATA) && !rx_empty;
    assign tx_accept = !tx_valid_q || uart_tx_ready;

    // Read data is sampled from the current state, before this cycle's pop or count update.
    always_comb begin
        rdata_d = '0;
        if (rd_req) begin
            case (word_off)
                OFF_STATUS:  rdata_d = {29'b0, tx_overflow_q, !rx_empty, !tx_valid_q};
                OFF_RX_DATA: begin
                    if (!rx_empty) begin
                        rdata_d = {24'b0, rx_mem_q[rx_rd_ptr_q]};
                    end
                end
                OFF_CYCLE:   rdata_d = cycle_cnt_q;
                OFF_INST:    rdata_d = inst_cnt_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        rx_mem_d    = rx_mem_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        if (rx_push) begin
            rx_mem_d[rx_wr_ptr_q] = uart_rx_data;
            rx_wr_ptr_d           = rx_wr_ptr_q + 1'b1;
        end
        if (rx_pop) begin
            rx_rd_ptr_d = rx_rd_ptr_q + 1'b1;
        end
        rx_count_d = rx_count_q + CNT_W'(rx_push) - CNT_W'(rx_pop);
    end

    always_comb begin
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        tx_overflow_d = tx_overflow_q;
        if (tx_wr) begin
            if (tx_accept) begin
                tx_data_d  = wdata[7:0];
                tx_valid_d = 1'b1;
            end else begin
                tx_overflow_d = 1'b1;
            end
        end else if (tx_valid_q && uart_tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (status_wr) begin
            tx_overflow_d = 1'b0;
        end
    end

    always_comb begin
        if (cnt_rst) begin
            cycle_cnt_d = '0;
            inst_cnt_d  = '0;
        end else begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            inst_cnt_d  = inst_cnt_q + {31'b0, inst_retired};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q       <= '0;
            rx_rd_ptr_q   <= '0;
            rx_wr_ptr_q   <= '0;
            rx_count_q    <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            tx_overflow_q <= 1'b0;
            cycle_cnt_q   <= '0;
            inst_cnt_q    <= '0;
        end else begin
            rdata_q       <= rdata_d;
            rx_rd_ptr_q   <= rx_rd_ptr_d;
            rx_wr_ptr_q   <= rx_wr_ptr_d;
            rx_count_q    <= rx_count_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_overflow_q <= tx_overflow_d;
            cycle_cnt_q   <= cycle_cnt_d;
            inst_cnt_q    <= inst_cnt_d;
        end
    end

    // Storage needs no reset: a slot is only ever read after it was pushed.
    always_ff @(posedge clk) begin
        rx_mem_q <= rx_mem_d;
    end

    assign rdata         = rdata_q;
    assign uart_rx_ready = !rx_full;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_valid = tx_valid_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: a queue/integer model of the register map checked every cycle,
// plus directed sequences with literal expectations.
module tb_mmio_responder;

    localparam int RX_DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic        re;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        inst_retired;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int n_cmp = 0;
    int n_bad = 0;
    logic chk_en = 1'b0;

    // Behavioural model state
    logic [7:0]  exp_q[$];
    logic [31:0] m_rdata;
    logic        m_tx_valid;
    logic [7:0]  m_tx_data;
    logic        m_ovf;
    logic [31:0] m_cycle;
    logic [31:0] m_inst;
    logic        m_sel;
    logic [7:0]  m_off;
    logic        m_was_full;
    logic [31:0] m_next_rdata;

    mmio_responder #(.RX_DEPTH(RX_DEPTH), .IO_BASE_NIBBLE(4'h8)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .re            (re),
        .we            (we),
        .wdata         (wdata),
        .wmask         (wmask),
        .inst_retired  (inst_retired),
        .rdata         (rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: register-map rules applied at each rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_rdata    = '0;
            m_tx_valid = 1'b0;
            m_tx_data  = '0;
            m_ovf      = 1'b0;
            m_cycle    = '0;
            m_inst     = '0;
            exp_q.delete();
        end else begin
            m_sel        = (addr[31:28] == 4'h8);
            m_off        = addr[7:0] & 8'hFC;
            m_was_full   = (exp_q.size() == RX_DEPTH);
            m_next_rdata = '0;
            if (re && !we && m_sel) begin
                if (m_off == 8'h00) begin
                    m_next_rdata = {29'b0, m_ovf, (exp_q.size() != 0), !m_tx_valid};
                end else if (m_off == 8'h04) begin
                    if (exp_q.size() != 0) begin
                        m_next_rdata = {24'b0, exp_q.pop_front()};
                    end
                end else if (m_off == 8'h10) begin
                    m_next_rdata = m_cycle;
                end else if (m_off == 8'h14) begin
                    m_next_rdata = m_inst;
                end
            end
            if (uart_rx_valid && !m_was_full) begin
                exp_q.push_back(uart_rx_data);
            end
            if (we && m_sel && m_off == 8'h08 && wmask[0]) begin
                if (!m_tx_valid || uart_tx_ready) begin
                    m_tx_data  = wdata[7:0];
                    m_tx_valid = 1'b1;
                end else begin
                    m_ovf = 1'b1;
                end
            end else if (m_tx_valid && uart_tx_ready) begin
                m_tx_valid = 1'b0;
            end
            if (we && m_sel && m_off == 8'h00 && wmask != 4'h0) begin
                m_ovf = 1'b0;
            end
            if (we && m_sel && m_off == 8'h18 && wmask != 4'h0) begin
                m_cycle = '0;
                m_inst  = '0;
            end else begin
                m_cycle = m_cycle + 32'd1;
                m_inst  = m_inst + {31'b0, inst_retired};
            end
            m_rdata = m_next_rdata;
        end
    end

    // Compare process: all outputs against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rdata", rdata, m_rdata);
            cmp("uart_tx_valid", 32'(uart_tx_valid), 32'(m_tx_valid));
            cmp("uart_tx_data", 32'(uart_tx_data), 32'(m_tx_data));
            cmp("uart_rx_ready", 32'(uart_rx_ready), 32'(exp_q.size() < RX_DEPTH));
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a;
        re   = 1'b1;
        step();
        re   = 1'b0;
        addr = '0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr  = a;
        wdata = d;
        wmask = m;
        we    = 1'b1;
        step();
        we    = 1'b0;
        wmask = '0;
        wdata = '0;
        addr  = '0;
    endtask

    initial begin
        logic [7:0] rx_bytes [4];
        rx_bytes[0] = 8'h41;
        rx_bytes[1] = 8'h42;
        rx_bytes[2] = 8'h43;
        rx_bytes[3] = 8'h44;

        rst = 1'b1; addr = '0; re = 1'b0; we = 1'b0; wdata = '0; wmask = '0;
        inst_retired = 1'b0; uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        cmp("reset_rdata", rdata, 32'h0);
        cmp("reset_rx_ready", 32'(uart_rx_ready), 32'h1);
        cmp("reset_tx_valid", 32'(uart_tx_valid), 32'h0);
        rst = 1'b0;

        rd(32'h8000_0000);
        cmp("status_after_reset", rdata, 32'h1);

        // Fill the RX FIFO, hold a fifth byte against back-pressure
        uart_rx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uart_rx_data = rx_bytes[i];
            step();
        end
        cmp("rx_full_ready", 32'(uart_rx_ready), 32'h0);
        uart_rx_data = 8'h45;
        step();
        cmp("rx_held_ready", 32'(uart_rx_ready), 32'h0);
        rd(32'h8000_0004);
        cmp("rx_pop_41", rdata, 32'h41);
        cmp("rx_ready_after_pop", 32'(uart_rx_ready), 32'h1);
        step();
        uart_rx_valid = 1'b0;
        cmp("rx_45_accepted_full", 32'(uart_rx_ready), 32'h0);
        rd(32'h8000_0004);
        cmp("rx_pop_42", rdata, 32'h42);
        rd(32'h8000_0004);
        cmp("rx_pop_43", rdata, 32'h43);
        rd(32'h8000_0004);
        cmp("rx_pop_44", rdata, 32'h44);
        rd(32'h8000_0004);
        cmp("rx_pop_45", rdata, 32'h45);
        rd(32'h8000_0004);
        cmp("rx_empty_read", rdata, 32'h0);

        // Push and void pop on an empty FIFO in the same cycle
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'h99;
        rd(32'h8000_0004);
        uart_rx_valid = 1'b0;
        cmp("rx_void_pop", rdata, 32'h0);
        rd(32'h8000_0000);
        cmp("status_rx_avail", rdata, 32'h3);
        rd(32'h8000_0004);
        cmp("rx_pop_99", rdata, 32'h99);

        // re and we together: write wins, no pop
        uart_rx_valid = 1'b1;
        uart_rx_data  = 8'hA5;
        step();
        uart_rx_valid = 1'b0;
        addr = 32'h8000_0004; re = 1'b1; we = 1'b1; wmask = 4'h1; wdata = 32'h0;
        step();
        re = 1'b0; we = 1'b0; wmask = 4'h0; addr = '0;
        cmp("re_we_rdata", rdata, 32'h0);
        rd(32'h8000_0004);
        cmp("rx_pop_a5", rdata, 32'hA5);

        // TX holding register and overflow
        uart_tx_ready = 1'b0;
        wr(32'h8000_0008, 32'h55, 4'h1);
        cmp("tx_valid_55", 32'(uart_tx_valid), 32'h1);
        cmp("tx_data_55", 32'(uart_tx_data), 32'h55);
        wr(32'h8000_0008, 32'h66, 4'h1);
        cmp("tx_data_held", 32'(uart_tx_data), 32'h55);
        rd(32'h8000_0000);
        cmp("status_overflow", rdata, 32'h4);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        cmp("tx_valid_cleared", 32'(uart_tx_valid), 32'h0);
        wr(32'h8000_0000, 32'h0, 4'hF);
        rd(32'h8000_0000);
        cmp("status_ovf_cleared", rdata, 32'h1);
        wr(32'h8000_0008, 32'h88, 4'h2);
        cmp("tx_no_lane0", 32'(uart_tx_valid), 32'h0);

        // New write during a handshake
        wr(32'h8000_0008, 32'h55, 4'h1);
        uart_tx_ready = 1'b1;
        wr(32'h8000_0008, 32'h77, 4'h1);
        cmp("tx_back2back_valid", 32'(uart_tx_valid), 32'h1);
        cmp("tx_back2back_data", 32'(uart_tx_data), 32'h77);
        step();
        uart_tx_ready = 1'b0;
        cmp("tx_drained", 32'(uart_tx_valid), 32'h0);

        // Counters
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            inst_retired = (i == 1 || i == 4 || i == 6);
            step();
        end
        inst_retired = 1'b0;
        rd(32'h8000_0010);
        cmp("cycle_cnt_10", rdata, 32'd10);
        rd(32'h8000_0014);
        cmp("inst_cnt_3", rdata, 32'd3);
        wr(32'h8000_0018, 32'h0, 4'h4);
        rd(32'h8000_0010);
        cmp("cycle_after_rst", rdata, 32'd0);
        rd(32'h8000_0014);
        cmp("inst_after_rst", rdata, 32'd0);

        // Wrap: preload the cycle counter to all ones
        force dut.cycle_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt_q;
        m_cycle = 32'hFFFF_FFFF;
        rd(32'h8000_0010);
        cmp("cycle_max", rdata, 32'hFFFF_FFFF);
        rd(32'h8000_0010);
        cmp("cycle_wrapped", rdata, 32'h0);

        // Unselected and unmapped accesses
        rd(32'h0000_1000);
        cmp("unsel_read", rdata, 32'h0);
        rd(32'h0000_1010);
        cmp("unsel_cycle_read", rdata, 32'h0);
        rd(32'h8000_0030);
        cmp("unmapped_read", rdata, 32'h0);
        wr(32'h0000_1008, 32'hEE, 4'h1);
        cmp("unsel_tx_write", 32'(uart_tx_valid), 32'h0);
        wr(32'h8000_0030, 32'hEE, 4'hF);

        // Reset while a read result is pending
        addr = 32'h8000_0010;
        re   = 1'b1;
        step();
        re   = 1'b0;
        addr = '0;
        rst  = 1'b1;
        step();
        cmp("rst_discards_read", rdata, 32'h0);
        rst = 1'b0;
        step();

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
